i2s_rx_capture: RTL and testbench

- Receives stereo PCM from the audio codec ADC serial port (bclk / adclrck / adcdat), in standard I2S format.
- This is the receiving counterpart of the I2S DAC transmit path that drives bclk/daclrck/dacdata.
- Synchronizes the codec-side signals into the system clock domain and deserializes left and right words.
- Presents each complete stereo frame on a valid/ready interface toward the DSP chain, with sticky error flags.

---
 rtl/i2s_rx_capture.sv | 179 +++++++++++++++++
 tb/tb_i2s_rx_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_capture.sv
// rtl/i2s_rx_capture.sv - I2S ADC receive path: synchronize, deserialize, present stereo frames
//
// Receives standard I2S stereo PCM from the codec ADC port and presents one
// stereo frame at a time on a valid/ready interface toward the DSP chain.
//
// Ports:
//   clk        system clock, at least 4x bclk
//   rst        synchronous reset, active-high
//   bclk       codec bit clock (asynchronous)
//   adclrck    codec word select (asynchronous), 0 = left, 1 = right
//   adcdat     codec serial data (asynchronous), MSB first
//   out_left   left sample, two's complement
//   out_right  right sample, two's complement
//   out_valid  stereo frame available
//   out_ready  downstream accepts the frame
//   ovf        sticky: frame dropped because the output was still occupied
//   err_short  sticky: a slot ended with fewer than DATA_W bits
//   clr_flags  single-cycle clear of ovf and err_short
`timescale 1ns/1ps
module i2s_rx_capture #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic              adclrck,
    input  logic              adcdat,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    output logic              err_short,
    input  logic              clr_flags
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;

    logic              bclk_prev;
    logic              l_prev;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] hold_left;

    logic              bclk_s;
    logic              l_cur;
    logic              d_cur;
    logic              rise;
    logic              boundary;
    logic              bit_take;
    logic              commit;
    logic              short_slot;
    logic              frame_done;
    logic              ovf_set;
    logic [DATA_W-1:0] word;

    assign bclk_s = bclk_sync[SYNC_STAGES-1];
    assign l_cur  = lrck_sync[SYNC_STAGES-1];
    assign d_cur  = dat_sync[SYNC_STAGES-1];

    always_comb begin
        rise       = bclk_s & ~bclk_prev;
        boundary   = rise && (l_cur != l_prev);
        // Bits beyond DATA_W in a slot are ignored; the counter saturates.
        bit_take   = rise && (state != ST_SYNC) && (cnt < CNT_FULL);
        commit     = bit_take && (cnt == CNT_LAST);
        word       = {shreg, d_cur};
        // The boundary bit is the ending slot's LSB, so it counts toward the
        // slot length: fewer than DATA_W bits means cnt was below DATA_W-1.
        short_slot = boundary && (state != ST_SYNC) && (cnt < CNT_LAST);
        frame_done = commit && (state == ST_RIGHT);
        ovf_set    = frame_done && out_valid && !out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            l_prev    <= 1'b0;
            state     <= ST_SYNC;
            cnt       <= '0;
            shreg     <= '0;
            hold_left <= '0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
            bclk_prev <= bclk_s;

            if (rise) begin
                l_prev <= l_cur;
            end

            if (bit_take) begin
                shreg <= {shreg[DATA_W-3:0], d_cur};
                cnt   <= cnt + CNT_ONE;
            end

            if (commit && (state == ST_LEFT)) begin
                hold_left <= word;
            end

            // A boundary restarts the count for the new slot, overriding the
            // increment of the boundary bit taken for the ending slot.
            case (state)
                ST_SYNC: begin
                    if (boundary && !l_cur) begin
                        state <= ST_LEFT;
                        cnt   <= '0;
                    end
                end
                ST_LEFT: begin
                    if (boundary) begin
                        cnt   <= '0;
                        state <= short_slot ? ST_SYNC : ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (boundary) begin
                        cnt   <= '0;
                        state <= short_slot ? ST_SYNC : ST_LEFT;
                    end
                end
                default: begin
                    state <= ST_SYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output register: a completed frame loads when the slot is empty or is
    // being transferred this clk; otherwise it is dropped and ovf is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            err_short <= 1'b0;
        end else begin
            if (frame_done && (!out_valid || out_ready)) begin
                out_left  <= hold_left;
                out_right <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end

            if (short_slot) begin
                err_short <= 1'b1;
            end else if (clr_flags) begin
                err_short <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb/tb_i2s_rx_capture.sv - self-checking bench for i2s_rx_capture
`timescale 1ns/1ps
module tb_i2s_rx_capture;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bclk = 1'b0;
    logic              adclrck = 1'b1;
    logic              adcdat = 1'b0;
    logic              out_ready = 1'b1;
    logic              clr_flags = 1'b0;
    logic [DATA_W-1:0] out_left;
    logic [DATA_W-1:0] out_right;
    logic              out_valid;
    logic              ovf;
    logic              err_short;

    int total = 0;
    int bad   = 0;

    // Serial stream under construction: data bit per bclk period and the
    // word-select value of the slot that owns that bit.
    bit          dq[$];
    bit          lrq[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    typedef struct {
        logic [31:0] tx_l;
        logic [31:0] tx_r;
        int          slen;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[8];

    always #10 clk = ~clk;

    i2s_rx_capture #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .adclrck   (adclrck),
        .adcdat    (adcdat),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .err_short (err_short),
        .clr_flags (clr_flags)
    );

    // Every transferred frame lands in the observed queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_left, out_right});
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_slot(input bit lr, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            dq.push_back(w[31-i]);
            lrq.push_back(lr);
        end
    endtask

    task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        add_slot(1'b0, l, n);
        add_slot(1'b1, r, n);
    endtask

    // Word select leads data by one bit: the period carrying a slot's last
    // bit already shows the next slot's word select.
    task automatic play_bits(input int k);
        repeat (k) begin
            bclk   = 1'b0;
            adcdat = dq.pop_front();
            void'(lrq.pop_front());
            adclrck = lrq[0];
            repeat (8) @(posedge clk);
            #1 bclk = 1'b1;
            repeat (8) @(posedge clk);
            #1;
        end
        bclk = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic play_rest();
        play_bits(dq.size() - 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Reset, then begin mid-way through a right slot.
    task automatic start_scn();
        @(posedge clk);
        #1 rst = 1'b1;
        adclrck = 1'b1;
        bclk    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        dq.delete();
        lrq.delete();
        add_slot(1'b1, $urandom, 10);
    endtask

    task automatic drain(input string tag);
        int n;
        logic [31:0] e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s frame%0d: got none expected %h", tag, i, e);
            end else begin
                check($sformatf("%s frame%0d", tag, i), obs_q.pop_front(), e);
            end
        end
        check({tag, " extra_frames"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        check({tag, " out_left"},  32'(out_left),  32'h0);
        check({tag, " out_right"}, 32'(out_right), 32'h0);
        check({tag, " out_valid"}, 32'(out_valid), 32'h0);
        check({tag, " ovf"},       32'(ovf),       32'h0);
        check({tag, " err_short"}, 32'(err_short), 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h8001_0000, 32'h7FFE_0000, 32, 16'h8001, 16'h7FFE};
        vecs[1] = '{32'h1234_5678, 32'h9ABC_DEF0, 32, 16'h1234, 16'h9ABC};
        vecs[2] = '{32'hC0DE_5A00, 32'h0F1E_2D00, 24, 16'hC0DE, 16'h0F1E};
        vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32, 16'h0000, 16'hFFFF};
        for (int i = 4; i < 8; i++) begin
            vecs[i] = '{32'hAAAA_0000, 32'h5555_0000, 16, 16'hAAAA, 16'h5555};
        end

        // Reset state
        repeat (3) @(posedge clk);
        check_zero_outputs("reset");

        // Startup mid-right-slot, then table of frames with out_ready=1
        out_ready = 1'b1;
        start_scn();
        for (int i = 0; i < 8; i++) begin
            add_frame(vecs[i].tx_l, vecs[i].tx_r, vecs[i].slen);
            exp_q.push_back({vecs[i].exp_l, vecs[i].exp_r});
        end
        add_slot(1'b0, 32'h0, 4);
        play_rest();
        drain("table");
        @(negedge clk);
        check("table err_short", 32'(err_short), 32'h0);
        check("table ovf",       32'(ovf),       32'h0);

        // Backpressure: A held, B dropped, then A transfers, clear, C flows
        out_ready = 1'b0;
        start_scn();
        add_frame(32'hA5A5_0000, 32'h5A5A_0000, 32);
        add_frame(32'h0F0F_0000, 32'hF0F0_0000, 32);
        add_frame(32'hC3C3_0000, 32'h3C3C_0000, 32);
        add_slot(1'b0, 32'h0, 4);
        exp_q.push_back(32'hA5A5_5A5A);
        exp_q.push_back(32'hC3C3_3C3C);
        play_bits(10 + 128);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp held_valid", 32'(out_valid), 32'h1);
        check("bp held_data", {out_left, out_right}, 32'hA5A5_5A5A);
        check("bp ovf_set", 32'(ovf), 32'h1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp valid_drop", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1 clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        @(negedge clk);
        check("bp ovf_clear", 32'(ovf), 32'h0);
        play_rest();
        drain("bp");

        // Short right slot: frame discarded, back to SYNC. The short slot's own
        // boundary is consumed, so the next frame is skipped while resyncing.
        out_ready = 1'b1;
        start_scn();
        add_frame(32'h1357_0000, 32'h2468_0000, 32);
        add_slot(1'b0, 32'h7777_0000, 32);
        add_slot(1'b1, 32'hFFFF_0000, 12);
        add_frame(32'h4444_0000, 32'h5555_0000, 32);
        add_frame(32'h6666_0000, 32'h9999_0000, 32);
        add_slot(1'b0, 32'h0, 4);
        exp_q.push_back(32'h1357_2468);
        exp_q.push_back(32'h6666_9999);
        play_rest();
        drain("short");
        @(negedge clk);
        check("short err_set", 32'(err_short), 32'h1);
        check("short ovf", 32'(ovf), 32'h0);
        @(posedge clk);
        #1 clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        @(negedge clk);
        check("short err_clear", 32'(err_short), 32'h0);

        // Reset during left-slot bit 7 with a frame held on the output
        out_ready = 1'b0;
        start_scn();
        add_frame(32'h0123_0000, 32'h4567_0000, 32);
        add_frame(32'h89AB_0000, 32'hCDEF_0000, 32);
        add_frame(32'hBEEF_0000, 32'hCAFE_0000, 32);
        add_frame(32'h8000_0000, 32'h0001_0000, 32);
        add_slot(1'b0, 32'h0, 4);
        exp_q.push_back(32'hBEEF_CAFE);
        exp_q.push_back(32'h8000_0001);
        play_bits(10 + 64 + 7);
        @(negedge clk);
        check("rstmid held_valid", 32'(out_valid), 32'h1);
        check("rstmid held_data", {out_left, out_right}, 32'h0123_4567);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("rstmid");
        out_ready = 1'b1;
        play_rest();
        drain("rstmid");
        @(negedge clk);
        check("rstmid err_short", 32'(err_short), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
